// File: rtl/uart_sched_pkg.sv
// ============================================================================
// Module      : uart_sched_pkg
// Description : Shared types, state encodings and helpers for uart_tx_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_sched_pkg;

    localparam int NREQ_MAX = 8;

    typedef logic [7:0] byte_t;
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SEND    = 3'd1;
    localparam state_t ST_START   = 3'd2;
    localparam state_t ST_WAIT_HI = 3'd3;
    localparam state_t ST_WAIT_LO = 3'd4;

    // Round-robin successor of a requester index.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first requester at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NREQ = 4
)(
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [$clog2(NREQ)-1:0] o_gnt_idx,
    output logic                    o_any
);

    localparam int IDXW = $clog2(NREQ);

    int w_k;

    // Scan from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        o_gnt_idx = '0;
        w_k       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= NREQ) begin
                w_k = w_k - NREQ;
            end
            if (i_req[w_k[IDXW-1:0]]) begin
                o_gnt_idx = w_k[IDXW-1:0];
            end
        end
    end

    assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Packet-locked round-robin sharing of one UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int BUSY_TO   = 8
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  byte_t [NREQ-1:0]        req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output byte_t                   uart_data,
    output logic                    uart_start,
    input  logic                    uart_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    active
);

    localparam int IDXW = $clog2(NREQ);
    localparam int BCW  = $clog2(MAX_BURST + 1);
    localparam int TOW  = $clog2(BUSY_TO);

    localparam logic [BCW-1:0] c_max_burst = BCW'(MAX_BURST);
    localparam logic [TOW-1:0] c_to_last   = TOW'(BUSY_TO - 1);

    state_t          r_state;
    state_t          w_next;
    logic [IDXW-1:0] r_grant;
    logic [IDXW-1:0] r_rr_ptr;
    logic [BCW-1:0]  r_beat_cnt;
    logic [TOW-1:0]  r_to_cnt;
    logic            r_last;
    byte_t           r_data;
    logic            r_start;
    logic            r_active;

    logic [IDXW-1:0] w_gnt_idx;
    logic            w_any;
    logic            w_fire;
    logic            w_release;

    rr_arbiter #(
        .NREQ      (NREQ)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    always_comb begin
        req_ready = '0;
        w_next    = r_state;
        w_fire    = 1'b0;
        w_release = r_last || (r_beat_cnt == c_max_burst);
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next = ST_SEND;
                end
            end
            ST_SEND: begin
                req_ready[r_grant] = ~uart_busy;
                w_fire             = req_valid[r_grant] & ~uart_busy;
                if (w_fire) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                w_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // A UART that never acknowledges must not stall the scheduler.
                if (uart_busy) begin
                    w_next = ST_WAIT_LO;
                end else if (r_to_cnt == c_to_last) begin
                    w_next = w_release ? ST_IDLE : ST_SEND;
                end
            end
            ST_WAIT_LO: begin
                if (!uart_busy) begin
                    w_next = w_release ? ST_IDLE : ST_SEND;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_start    <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_start  <= (w_next == ST_START);
            r_active <= (w_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_gnt_idx;
                        r_beat_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (w_fire) begin
                        r_data     <= req_data[r_grant];
                        r_last     <= req_last[r_grant];
                        r_beat_cnt <= r_beat_cnt + BCW'(1);
                    end
                end
                ST_START: begin
                    r_to_cnt <= '0;
                end
                ST_WAIT_HI: begin
                    if (!uart_busy && r_to_cnt != c_to_last) begin
                        r_to_cnt <= r_to_cnt + TOW'(1);
                    end
                end
                default: begin
                end
            endcase
            if (r_state != ST_IDLE && w_next == ST_IDLE) begin
                r_rr_ptr <= IDXW'(wrap_inc(int'(r_grant), NREQ));
            end
        end
    end

    assign uart_data  = r_data;
    assign uart_start = r_start;
    assign grant_id   = r_grant;
    assign active     = r_active;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Self-checking bench with requester/UART models and a packet-level scheduler model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 16;
    localparam int BUSY_TO   = 8;
    localparam int LIMIT     = 5000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    byte_t [NREQ-1:0]        req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_ready;
    byte_t                   uart_data;
    logic                    uart_start;
    logic                    uart_busy;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    active;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NREQ       (NREQ),
        .MAX_BURST  (MAX_BURST),
        .BUSY_TO    (BUSY_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_data  (uart_data),
        .uart_start (uart_start),
        .uart_busy  (uart_busy),
        .grant_id   (grant_id),
        .active     (active)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    byte_t dq[NREQ][$];
    bit    lq[NREQ][$];
    int    exp_id[$];
    byte_t exp_d[$];
    int    obs_id[$];
    byte_t obs_d[$];
    int    obs_cyc[$];
    int    rdy_cnt[NREQ];
    int    mptr = 0;
    int    cyc = 0;
    bit    never_busy = 1'b0;
    bit    pend = 1'b0;
    bit    prev_start = 1'b0;
    bit    s_start;
    int    dcnt, bcnt;
    logic [NREQ-1:0] hs;

    // Requester queues + UART busy model; inputs change #1 after posedge, outputs sampled on negedge.
    always begin
        @(negedge clk);
        cyc++;
        hs      = req_valid & req_ready;
        s_start = uart_start;
        if (!rst) begin
            n_tests++;
            if (!$onehot0(req_ready)) begin
                n_fail++;
                $display("FAIL ready_onehot0: req_ready=%b, required one-hot or zero", req_ready);
            end
            n_tests++;
            if (s_start && prev_start) begin
                n_fail++;
                $display("FAIL start_pulse: uart_start=1 two cycles in a row at cycle %0d, required single pulse", cyc);
            end
            for (int i = 0; i < NREQ; i++) rdy_cnt[i] += int'(req_ready[i]);
            if (s_start) begin
                obs_id.push_back(int'(grant_id));
                obs_d.push_back(uart_data);
                obs_cyc.push_back(cyc);
            end
        end
        prev_start = s_start;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && dq[i].size() > 0) begin
                void'(dq[i].pop_front());
                void'(lq[i].pop_front());
            end
        end
        if (s_start && !never_busy) begin
            pend = 1'b1;
            dcnt = $urandom_range(0, 3);
            bcnt = $urandom_range(1, 5);
        end
        if (pend) begin
            if (dcnt == 0) begin
                pend      = 1'b0;
                uart_busy = 1'b1;
            end else begin
                dcnt--;
            end
        end else if (uart_busy) begin
            if (bcnt <= 1) uart_busy = 1'b0;
            else bcnt--;
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (dq[i].size() > 0);
            req_data[i]  = (dq[i].size() > 0) ? dq[i][0] : 8'h00;
            req_last[i]  = (lq[i].size() > 0) ? lq[i][0] : 1'b0;
        end
    end

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (dq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_beat(input int r, input byte_t d, input bit l);
        dq[r].push_back(d);
        lq[r].push_back(l);
    endtask

    task automatic clear_obs();
        obs_id.delete(); obs_d.delete(); obs_cyc.delete();
        for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
    endtask

    // Packet-level reference: round-robin over packets, a grant ends at last or after MAX_BURST beats.
    task automatic model_build();
        byte_t mq[NREQ][$];
        bit    ml[NREQ][$];
        int    g, n;
        bit    found, lst, go;
        for (int r = 0; r < NREQ; r++) begin
            mq[r] = dq[r];
            ml[r] = lq[r];
        end
        exp_id.delete(); exp_d.delete();
        go = 1'b1;
        while (go) begin
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && mq[(mptr + k) % NREQ].size() > 0) begin
                    found = 1'b1;
                    g     = (mptr + k) % NREQ;
                end
            end
            if (!found) begin
                go = 1'b0;
            end else begin
                n   = 0;
                lst = 1'b0;
                while (!lst && n < MAX_BURST && mq[g].size() > 0) begin
                    exp_id.push_back(g);
                    exp_d.push_back(mq[g].pop_front());
                    lst = ml[g].pop_front();
                    n++;
                end
                if (!lst && n < MAX_BURST) go = 1'b0;
                else mptr = (g + 1) % NREQ;
            end
        end
    endtask

    task automatic drain(output bit timed_out);
        int t = 0;
        while (t < LIMIT && !(all_empty() && !active && !uart_busy && !pend)) begin
            @(negedge clk);
            t++;
        end
        timed_out = (t >= LIMIT);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst  = 1'b1;
        mptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (uart_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b, required 0", uart_start); end
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", req_ready); end
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b, required 0", active); end
        n_tests++; if (grant_id !== '0) begin n_fail++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
        n_tests++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, required 00", uart_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit to;
        clear_obs();
        push_beat(0, 8'h55, 1'b1);
        model_build();
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL single_drain: timed out, required idle within %0d cycles", LIMIT); end
        n_tests++; if (obs_d.size() != 1 || obs_d[0] !== 8'h55) begin n_fail++; $display("FAIL single_byte: got %0d starts, required one start of 55", obs_d.size()); end
        n_tests++; if (rdy_cnt[0] != 1) begin n_fail++; $display("FAIL single_ready: req_ready[0] high %0d cycles, required 1", rdy_cnt[0]); end
        // Pointer must now sit at 1, so req1 beats req0.
        clear_obs();
        push_beat(0, 8'h10, 1'b1);
        push_beat(1, 8'h11, 1'b1);
        model_build();
        drain(to);
        n_tests++; if (to || obs_id.size() != 2 || obs_id[0] != 1) begin n_fail++; $display("FAIL single_rrptr: first grant after single was %0d (%0d starts), required 1", (obs_id.size() > 0) ? obs_id[0] : -1, obs_id.size()); end
    endtask

    task automatic test_contention();
        bit to;
        pulse_reset();
        clear_obs();
        for (int p = 0; p < 2; p++) for (int r = 0; r < NREQ; r++) push_beat(r, byte_t'(8'hC0 + 4 * p + r), 1'b1);
        model_build();
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL contention_drain: timed out"); end
        n_tests++; if (obs_d.size() != exp_d.size()) begin n_fail++; $display("FAIL contention_count: got %0d bytes, required %0d", obs_d.size(), exp_d.size()); end
        for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
            n_tests++;
            if (obs_id[k] != exp_id[k] || obs_d[k] !== exp_d[k] || obs_id[k] != k % NREQ) begin
                n_fail++; $display("FAIL contention_order[%0d]: got req%0d/%h, required req%0d/%h", k, obs_id[k], obs_d[k], k % NREQ, exp_d[k]);
            end
            if (k > 0) begin
                n_tests++;
                if (obs_id[k] == obs_id[k-1]) begin n_fail++; $display("FAIL contention_repeat[%0d]: req%0d granted twice in a row, required different", k, obs_id[k]); end
            end
        end
    endtask

    task automatic test_packet_lock();
        bit to;
        pulse_reset();
        clear_obs();
        push_beat(0, 8'hA1, 1'b0);
        push_beat(0, 8'hA2, 1'b0);
        push_beat(0, 8'hA3, 1'b1);
        push_beat(1, 8'hB0, 1'b1);
        model_build();
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL lock_drain: timed out"); end
        n_tests++; if (obs_d.size() != 4) begin n_fail++; $display("FAIL lock_count: got %0d bytes, required 4", obs_d.size()); end
        for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
            n_tests++;
            if (obs_id[k] != exp_id[k] || obs_d[k] !== exp_d[k]) begin
                n_fail++; $display("FAIL lock_order[%0d]: got req%0d/%h, required req%0d/%h", k, obs_id[k], obs_d[k], exp_id[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_fairness();
        bit to;
        pulse_reset();
        clear_obs();
        for (int b = 0; b < 20; b++) push_beat(2, byte_t'(8'h20 + b), b == 19);
        push_beat(3, 8'hF3, 1'b1);
        model_build();
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL fair_drain: timed out"); end
        n_tests++; if (obs_d.size() != 21) begin n_fail++; $display("FAIL fair_count: got %0d bytes, required 21", obs_d.size()); end
        n_tests++; if (obs_id.size() > 16 && (obs_id[16] != 3 || obs_d[16] !== 8'hF3)) begin n_fail++; $display("FAIL fair_handover: beat 17 from req%0d/%h, required req3/f3", obs_id[16], obs_d[16]); end
        for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
            n_tests++;
            if (obs_id[k] != exp_id[k] || obs_d[k] !== exp_d[k]) begin
                n_fail++; $display("FAIL fair_order[%0d]: got req%0d/%h, required req%0d/%h", k, obs_id[k], obs_d[k], exp_id[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_busy_timeout();
        bit to;
        never_busy = 1'b1;
        clear_obs();
        push_beat(1, 8'h5A, 1'b0);
        push_beat(1, 8'h5B, 1'b0);
        push_beat(1, 8'h5C, 1'b1);
        model_build();
        drain(to);
        never_busy = 1'b0;
        n_tests++; if (to) begin n_fail++; $display("FAIL timeout_drain: scheduler hung with silent UART"); end
        n_tests++; if (obs_d.size() != 3) begin n_fail++; $display("FAIL timeout_count: got %0d starts, required 3", obs_d.size()); end
        for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
            n_tests++;
            if (obs_id[k] != exp_id[k] || obs_d[k] !== exp_d[k]) begin
                n_fail++; $display("FAIL timeout_order[%0d]: got req%0d/%h, required req%0d/%h", k, obs_id[k], obs_d[k], exp_id[k], exp_d[k]);
            end
            if (k > 0) begin
                n_tests++;
                if (obs_cyc[k] - obs_cyc[k-1] != BUSY_TO + 2) begin
                    n_fail++; $display("FAIL timeout_gap[%0d]: got %0d cycles between starts, required %0d", k, obs_cyc[k] - obs_cyc[k-1], BUSY_TO + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        bit to;
        int t = 0;
        clear_obs();
        push_beat(2, 8'h3C, 1'b0);
        push_beat(2, 8'h3D, 1'b1);
        while (t < 200 && !(uart_busy && active)) begin
            @(negedge clk);
            t++;
        end
        n_tests++; if (t >= 200) begin n_fail++; $display("FAIL rstmid_reach: never reached busy-high wait"); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (uart_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %b, required 0", uart_start); end
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL rstmid_ready: got %b, required 0", req_ready); end
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL rstmid_active: got %b, required 0", active); end
        for (int i = 0; i < NREQ; i++) begin dq[i].delete(); lq[i].delete(); end
        mptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_obs();
        push_beat(3, 8'h77, 1'b1);
        push_beat(0, 8'h11, 1'b1);
        model_build();
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL rstmid_drain: timed out"); end
        n_tests++; if (obs_id.size() != 2 || obs_id[0] != 0 || obs_d[0] !== 8'h11) begin n_fail++; $display("FAIL rstmid_first: first grant req%0d (%0d starts), required req0/11", (obs_id.size() > 0) ? obs_id[0] : -1, obs_id.size()); end
    endtask

    task automatic test_random();
        bit to;
        int len;
        for (int round = 0; round < 4; round++) begin
            clear_obs();
            for (int r = 0; r < NREQ; r++) begin
                if ($urandom_range(0, 3) != 0) begin
                    for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
                        len = $urandom_range(1, 20);
                        for (int b = 0; b < len; b++) push_beat(r, byte_t'($urandom_range(0, 255)), b == len - 1);
                    end
                end
            end
            model_build();
            drain(to);
            n_tests++; if (to) begin n_fail++; $display("FAIL random%0d_drain: timed out", round); end
            n_tests++; if (obs_d.size() != exp_d.size()) begin n_fail++; $display("FAIL random%0d_count: got %0d bytes, required %0d", round, obs_d.size(), exp_d.size()); end
            for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
                n_tests++;
                if (obs_id[k] != exp_id[k] || obs_d[k] !== exp_d[k]) begin
                    n_fail++; $display("FAIL random%0d_order[%0d]: got req%0d/%h, required req%0d/%h", round, k, obs_id[k], obs_d[k], exp_id[k], exp_d[k]);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        uart_busy = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_packet_lock();
        test_fairness();
        test_busy_timeout();
        test_reset_mid_byte();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
